// File: rtl/aes256_key_sched_ctrl.sv
// Iterative AES-256 key expansion: one 32-bit schedule word per cycle, round keys rk0..rk14 out as 128-bit pulses.
// Latency: rk0 on the accepting edge, rk1 one edge later, rk_n (n>=2) at accept+4n-3; done with rk14 at accept+53.
// No backpressure: the consumer must capture on rk_valid; start is ignored while busy.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start, key_in     : launch request and 256-bit cipher key (w0 = key_in[255:224])
//   busy, done        : run in progress; one-cycle pulse alongside rk_idx = 14
//   rk_valid/idx/data : round-key pulse, index 0..14, {w[4n], w[4n+1], w[4n+2], w[4n+3]}
//   sbox_in, sbox_out : borrowed combinational SubWord bank (4 bytes in parallel)

// Round constant lookup: index 0..6 -> 01,02,04,08,10,20,40.
module aes_rcon (
    input  logic [2:0] idx_i,
    output logic [7:0] rcon_o
);
    always_comb begin
        unique case (idx_i)
            3'd0:    rcon_o = 8'h01;
            3'd1:    rcon_o = 8'h02;
            3'd2:    rcon_o = 8'h04;
            3'd3:    rcon_o = 8'h08;
            3'd4:    rcon_o = 8'h10;
            3'd5:    rcon_o = 8'h20;
            3'd6:    rcon_o = 8'h40;
            default: rcon_o = 8'h80;
        endcase
    end
endmodule

module aes256_key_sched_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out
);
    typedef enum logic [1:0] {ST_IDLE, ST_EMIT1, ST_GEN} state_t;

    state_t             state_q, state_d;
    logic [7:0][31:0]   win_q, win_d;      // win[0] = w[i-8] .. win[7] = w[i-1]
    logic [5:0]         i_q, i_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rk_valid_q, rk_valid_d;
    logic [3:0]         rk_idx_q, rk_idx_d;
    logic [127:0]       rk_data_q, rk_data_d;

    logic [31:0]        rot_word;
    logic [31:0]        temp;
    logic [31:0]        new_word;
    logic [2:0]         rcon_idx;
    logic [7:0]         rcon;

    // i/8 runs 1..7 for the words that need a round constant
    assign rcon_idx = i_q[5:3] - 3'd1;

    aes_rcon u_rcon (
        .idx_i  (rcon_idx),
        .rcon_o (rcon)
    );

    assign rot_word = {win_q[7][23:0], win_q[7][31:24]};
    assign sbox_in  = (i_q[2:0] == 3'd0) ? rot_word : win_q[7];

    always_comb begin
        temp = win_q[7];
        if (i_q[2:0] == 3'd0) begin
            temp = sbox_out ^ {rcon, 24'h0};
        end else if (i_q[1:0] == 2'd0) begin
            temp = sbox_out;                    // i%8 == 4: extra SubWord of AES-256
        end
    end

    assign new_word = win_q[0] ^ temp;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        i_d        = i_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rk_valid_d = 1'b0;
        rk_idx_d   = rk_idx_q;
        rk_data_d  = rk_data_q;

        unique case (state_q)
            ST_IDLE: begin
                // The cycle carrying done is idle but refuses start, so rk_valid
                // and done always drop for one cycle between back-to-back runs.
                if (start && !done_q) begin
                    for (int k = 0; k < 8; k++) begin
                        win_d[k] = key_in[255 - 32*k -: 32];
                    end
                    busy_d     = 1'b1;
                    rk_valid_d = 1'b1;
                    rk_idx_d   = 4'd0;
                    rk_data_d  = key_in[255:128];
                    state_d    = ST_EMIT1;
                end
            end
            ST_EMIT1: begin
                rk_valid_d = 1'b1;
                rk_idx_d   = 4'd1;
                rk_data_d  = {win_q[4], win_q[5], win_q[6], win_q[7]};
                i_d        = 6'd8;
                state_d    = ST_GEN;
            end
            ST_GEN: begin
                win_d[6:0] = win_q[7:1];
                win_d[7]   = new_word;
                i_d        = i_q + 6'd1;
                // Last word of a round key completes it: idx = (i-3)/4 = i[5:2]
                if (i_q[1:0] == 2'd3) begin
                    rk_valid_d = 1'b1;
                    rk_idx_d   = i_q[5:2];
                    rk_data_d  = {win_q[5], win_q[6], win_q[7], new_word};
                end
                if (i_q == 6'd59) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            i_q        <= 6'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= 4'd0;
            rk_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            i_q        <= i_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rk_valid_q <= rk_valid_d;
            rk_idx_q   <= rk_idx_d;
            rk_data_q  <= rk_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rk_valid = rk_valid_q;
    assign rk_idx   = rk_idx_q;
    assign rk_data  = rk_data_q;

endmodule
